// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8 data bits LSB first, optional parity, one stop bit.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority bit decisions around mid-bit.
module uart_rx #(
    parameter int OVERSAMPLE = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       DATA_VALID,
    output logic       PAR_ERR,
    output logic       STP_ERR,
    output logic       RX_BUSY
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] C_EARLY  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_MID    = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_DECIDE = CW'(OVERSAMPLE / 2 + 1);
`else
    localparam logic [CW-1:0] C_DECIDE = CW'(OVERSAMPLE / 2);
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_sample;
    logic [2:0]    r_bitCnt;
    logic [7:0]    r_shift;
    logic          r_parEn;
    logic          r_parTyp;
    logic          r_parBad;
    logic          r_armed;
    logic [7:0]    r_pData;
    logic          r_dataValid;
    logic          r_parErr;
    logic          r_stpErr;
    logic          r_busy;

    logic w_rx;
    logic w_bit;
    logic w_decide;
    logic w_endBit;
    logic w_expPar;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX_IN;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx     = r_sync2;
    assign w_decide = (r_sample == C_DECIDE);
    assign w_endBit = (r_sample == C_LAST);
    assign w_expPar = r_parTyp ? (^r_shift) : (~^r_shift);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_vote0;
    logic r_vote1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vote0 <= 1'b1;
            r_vote1 <= 1'b1;
        end else begin
            if (r_sample == C_EARLY) r_vote0 <= w_rx;
            if (r_sample == C_MID)   r_vote1 <= w_rx;
        end
    end

    assign w_bit = (r_vote0 & r_vote1) | (r_vote0 & w_rx) | (r_vote1 & w_rx);
`else
    assign w_bit = w_rx;
`endif

    // The falling-edge cycle seen in IDLE counts as sample 0 of the start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sample    <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_parEn     <= 1'b0;
            r_parTyp    <= 1'b0;
            r_parBad    <= 1'b0;
            r_armed     <= 1'b1;
            r_pData     <= 8'h00;
            r_dataValid <= 1'b0;
            r_parErr    <= 1'b0;
            r_stpErr    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_dataValid <= 1'b0;
            r_parErr    <= 1'b0;
            r_stpErr    <= 1'b0;
            r_sample    <= w_endBit ? '0 : r_sample + 1'b1;
            case (r_state)
                IDLE: begin
                    r_sample <= '0;
                    if (!r_armed) begin
                        if (w_rx) r_armed <= 1'b1;
                    end else if (!w_rx) begin
                        r_state  <= START;
                        r_sample <= CW'(1);
                        r_bitCnt <= '0;
                    end
                end
                START: begin
                    if (w_decide && w_bit) begin
                        r_state  <= IDLE;
                        r_sample <= '0;
                    end else begin
                        if (w_decide) begin
                            r_parEn  <= PAR_EN;
                            r_parTyp <= PAR_TYP;
                            r_parBad <= 1'b0;
                            r_busy   <= 1'b1;
                        end
                        if (w_endBit) r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_decide) r_shift <= {w_bit, r_shift[7:1]};
                    if (w_endBit) begin
                        r_bitCnt <= r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) r_state <= r_parEn ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (w_decide) r_parBad <= (w_bit != w_expPar);
                    if (w_endBit) r_state <= STOP;
                end
                STOP: begin
                    // Leave at mid-stop so a following start bit is never missed.
                    if (w_decide) begin
                        r_state     <= IDLE;
                        r_sample    <= '0;
                        r_busy      <= 1'b0;
                        r_stpErr    <= ~w_bit;
                        r_parErr    <= r_parBad;
                        r_dataValid <= w_bit & ~r_parBad;
                        if (w_bit && !r_parBad) r_pData <= r_shift;
                        if (!w_bit) r_armed <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_sample <= '0;
                end
            endcase
        end
    end

    assign P_DATA     = r_pData;
    assign DATA_VALID = r_dataValid;
    assign PAR_ERR    = r_parErr;
    assign STP_ERR    = r_stpErr;
    assign RX_BUSY    = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx using directed vectors, corner sequences
// and random frames compared against a frame-level reference model.
module tb_uart_rx;
   localparam int OS = 8;
`ifdef UART_RX_MAJORITY_VOTE_EN
   localparam int MV = 1;
`else
   localparam int MV = 0;
`endif

   logic       clk;
   logic       reset;
   logic       RX_IN;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_ERR;
   logic       STP_ERR;
   logic       RX_BUSY;

   typedef struct {
      logic [7:0] data;
      logic       parEn;
      logic       parTyp;
      logic       parBit;
      logic       stopBit;
      logic       expDv;
      logic       expPe;
      logic       expSe;
   } vec_t;

   typedef struct {
      int         cyc;
      logic       dv;
      logic       pe;
      logic       se;
      logic [7:0] pd;
   } ev_t;

   ev_t        evQ[$];
   int         cycleCount;
   int         total;
   int         bad;
   logic [7:0] lastGood;

   uart_rx #(.OVERSAMPLE(OS)) dut (
      .clk       (clk),
      .reset     (reset),
      .RX_IN     (RX_IN),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .P_DATA    (P_DATA),
      .DATA_VALID(DATA_VALID),
      .PAR_ERR   (PAR_ERR),
      .STP_ERR   (STP_ERR),
      .RX_BUSY   (RX_BUSY)
   );

   // Free-running clock with a cycle counter used to time-stamp result pulses.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycleCount = 0;
   always @(posedge clk) cycleCount++;

   // Record every cycle in which any result pulse is high, sampled mid-cycle.
   always @(negedge clk) begin
      ev_t e;
      if (DATA_VALID === 1'b1 || PAR_ERR === 1'b1 || STP_ERR === 1'b1) begin
         e.cyc = cycleCount;
         e.dv  = DATA_VALID;
         e.pe  = PAR_ERR;
         e.se  = STP_ERR;
         e.pd  = P_DATA;
         evQ.push_back(e);
      end
   end

   // Watchdog so the run always ends even if the stimulus stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Frame-level reference: parity and stop checks from the frame fields alone.
   function automatic logic [2:0] refOutcome(input logic [7:0] d, input logic pe, input logic pt,
                                             input logic pb, input logic sb);
      logic expPar;
      logic parBad;
      expPar = pt ? (^d) : (~^d);
      parBad = pe && (pb != expPar);
      return {(!parBad && sb), parBad, !sb};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) begin
         RX_IN = 1'b1;
         @(negedge clk);
      end
   endtask

   // Drive one frame starting at a falling clock edge; optional one-cycle glitch or mid-frame reset.
   task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt, input logic pb,
                                input logic sb, input int glitchBit, input int glitchOff,
                                input int resetAt, output int startCyc, output logic busyMid);
      logic bits [0:10];
      int   nb;
      busyMid = 1'b0;
      nb = pe ? 11 : 10;
      bits[0] = 1'b0;
      for (int j = 0; j < 8; j++) bits[j+1] = d[j];
      bits[9]  = pe ? pb : sb;
      bits[10] = sb;
      PAR_EN   = pe;
      PAR_TYP  = pt;
      startCyc = cycleCount;
      for (int i = 0; i < nb * OS; i++) begin
         int j;
         int o;
         j = i / OS;
         o = i % OS;
         if (i == resetAt) begin
            reset = 1'b1;
            RX_IN = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            return;
         end
         if (i == 3 * OS) begin
            PAR_EN  = 1'($urandom);
            PAR_TYP = 1'($urandom);
         end
         if (i == 5 * OS) busyMid = RX_BUSY;
         RX_IN = bits[j] ^ ((j == glitchBit && o == glitchOff) ? 1'b1 : 1'b0);
         @(negedge clk);
      end
   endtask

   task automatic checkEvent(input string tag, input logic expDv, input logic expPe, input logic expSe,
                             input logic [7:0] d, input int cyc);
      ev_t e;
      if (evQ.size() == 0) begin
         checkOutput({tag, " pulse count"}, 0, 1);
         return;
      end
      e = evQ.pop_front();
      checkOutput({tag, " pulse cycle"}, e.cyc, cyc);
      checkOutput({tag, " DATA_VALID"}, e.dv, expDv);
      checkOutput({tag, " PAR_ERR"}, e.pe, expPe);
      checkOutput({tag, " STP_ERR"}, e.se, expSe);
      if (expDv) checkOutput({tag, " P_DATA at pulse"}, e.pd, d);
   endtask

   task automatic checkNone(input string tag);
      checkOutput({tag, " extra pulses"}, evQ.size(), 0);
      evQ.delete();
   endtask

   task automatic runFrame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                           input logic pb, input logic sb, input logic expDv, input logic expPe,
                           input logic expSe, input int gBit, input int gOff);
      int   st;
      logic bm;
      applyStimulus(d, pe, pt, pb, sb, gBit, gOff, -1, st, bm);
      idleCycles(4);
      checkEvent(tag, expDv, expPe, expSe, d, st + 2 + OS * (pe ? 10 : 9) + OS / 2 + 1 + MV);
      checkNone(tag);
      if (expDv) lastGood = d;
      checkOutput({tag, " P_DATA hold"}, P_DATA, lastGood);
      checkOutput({tag, " RX_BUSY idle"}, RX_BUSY, 0);
      checkOutput({tag, " RX_BUSY mid"}, bm, 1);
   endtask

   initial begin
      vec_t       vecs[7];
      logic [2:0] r;
      logic [7:0] d;
      logic       pe, pt, pb, sb;
      int         st;
      int         busyCnt;
      logic       bm;

      vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      total    = 0;
      bad      = 0;
      lastGood = 8'h00;
      reset    = 1'b1;
      RX_IN    = 1'b1;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset P_DATA", P_DATA, 8'h00);
      checkOutput("reset DATA_VALID", DATA_VALID, 0);
      checkOutput("reset PAR_ERR", PAR_ERR, 0);
      checkOutput("reset STP_ERR", STP_ERR, 0);
      checkOutput("reset RX_BUSY", RX_BUSY, 0);

      for (int i = 0; i < 7; i++)
         runFrame($sformatf("vec%0d", i), vecs[i].data, vecs[i].parEn, vecs[i].parTyp,
                  vecs[i].parBit, vecs[i].stopBit, vecs[i].expDv, vecs[i].expPe, vecs[i].expSe, -1, -1);

      runFrame("early glitch", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
      runFrame("mid glitch", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6, OS / 2);
`endif

      busyCnt = 0;
      RX_IN = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         RX_IN = 1'b1;
         if (RX_BUSY === 1'b1) busyCnt++;
         @(negedge clk);
      end
      checkOutput("false start busy", busyCnt, 0);
      checkNone("false start");

      applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1, st, bm);
      busyCnt = 0;
      for (int k = 0; k < 40; k++) begin
         RX_IN = 1'b0;
         if (RX_BUSY === 1'b1) busyCnt++;
         @(negedge clk);
      end
      idleCycles(4);
      checkEvent("break", 1'b0, 1'b0, 1'b1, 8'h3C, st + 2 + OS * 9 + OS / 2 + 1 + MV);
      checkNone("break");
      checkOutput("break busy retrigger", busyCnt, 0);
      runFrame("after break", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);

      begin
         int st2;
         applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, -1, st, bm);
         applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, -1, st2, bm);
         idleCycles(4);
         checkEvent("b2b first", 1'b1, 1'b0, 1'b0, 8'h00, st + 2 + OS * 9 + OS / 2 + 1 + MV);
         checkEvent("b2b second", 1'b1, 1'b0, 1'b0, 8'hFF, st2 + 2 + OS * 9 + OS / 2 + 1 + MV);
         checkNone("b2b");
         lastGood = 8'hFF;
         checkOutput("b2b P_DATA", P_DATA, lastGood);
      end

      applyStimulus(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 5 * OS + OS / 2, st, bm);
      checkOutput("midreset busy before", bm, 1);
      checkOutput("midreset P_DATA", P_DATA, 8'h00);
      checkOutput("midreset RX_BUSY", RX_BUSY, 0);
      checkOutput("midreset DATA_VALID", DATA_VALID, 0);
      checkOutput("midreset PAR_ERR", PAR_ERR, 0);
      checkOutput("midreset STP_ERR", STP_ERR, 0);
      idleCycles(20);
      checkNone("midreset");
      lastGood = 8'h00;
      runFrame("post reset", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);

      for (int k = 0; k < 24; k++) begin
         d  = 8'($urandom);
         pe = 1'($urandom);
         pt = 1'($urandom);
         pb = 1'($urandom);
         sb = ($urandom_range(0, 4) != 0);
         r  = refOutcome(d, pe, pt, pb, sb);
         runFrame($sformatf("rand%0d", k), d, pe, pt, pb, sb, r[2], r[1], r[0], -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
